// File: rtl/pwm_generador_if.sv
// Signal bundle between the PWM control logic and pwm_generador.
// Period_end is present only when PWM_PERIOD_PULSE_EN is defined.
interface pwm_generador_if #(
  parameter int WIDTH = 8
);
  logic             Clock_div;
  logic             Enable;
  logic [WIDTH-1:0] Duty;
  logic             Duty_load;
  logic             PWM_out;
  logic             Duty_pending;
  logic             Running;
`ifdef PWM_PERIOD_PULSE_EN
  logic             Period_end;

  modport master (
    output Clock_div, Enable, Duty, Duty_load,
    input  PWM_out, Duty_pending, Running, Period_end
  );
  modport slave (
    input  Clock_div, Enable, Duty, Duty_load,
    output PWM_out, Duty_pending, Running, Period_end
  );
`else
  modport master (
    output Clock_div, Enable, Duty, Duty_load,
    input  PWM_out, Duty_pending, Running
  );
  modport slave (
    input  Clock_div, Enable, Duty, Duty_load,
    output PWM_out, Duty_pending, Running
  );
`endif
endinterface

// File: rtl/pwm_generador.sv
// PWM stage behind the frequency divider: edge-detected ticks, period counter, double-buffered duty.
// Optional Period_end wrap pulse is enabled with the PWM_PERIOD_PULSE_EN macro.
module pwm_generador #(
  parameter int WIDTH  = 8,
  parameter int PERIOD = 255
) (
  input  logic             Clock_in,
  input  logic             Reset,
  pwm_generador_if.slave   bus
);

  localparam logic [WIDTH-1:0] TERM = WIDTH'(PERIOD);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state_q, state_eff, state_n;
  logic [WIDTH-1:0] count_q, count_n;
  logic [WIDTH-1:0] active_q, active_n;
  logic [WIDTH-1:0] shadow_q, shadow_n;
  logic             pending_q, pending_n;
  logic             div_q;
  logic             pwm_q, pwm_n;
  logic             running_q;
  logic             tick, wrap, apply;

  always_comb begin
    tick      = bus.Clock_div & ~div_q;
    state_eff = state_q;
    // Enable-driven transition comes first; the tick is then judged under the new state.
    case (state_q)
      IDLE:    if (bus.Enable)  state_eff = RUN;
      RUN:     if (!bus.Enable) state_eff = DRAIN;
      DRAIN:   if (bus.Enable)  state_eff = RUN;
      default: state_eff = IDLE;
    endcase

    wrap  = tick && (state_eff != IDLE) && (count_q == TERM);
    apply = ((state_q == IDLE) && pending_q) || wrap;

    state_n = state_eff;
    count_n = count_q;
    if (tick && (state_eff != IDLE))
      count_n = wrap ? '0 : count_q + 1'b1;
    if (wrap && (state_eff == DRAIN))
      state_n = IDLE;

    shadow_n  = shadow_q;
    active_n  = active_q;
    pending_n = pending_q;
    if (apply) begin
      active_n  = shadow_q;
      pending_n = 1'b0;
    end
    // A load landing on an apply point bypasses the shadow so nothing is left pending.
    if (bus.Duty_load) begin
      shadow_n = bus.Duty;
      if (apply) active_n  = bus.Duty;
      else       pending_n = 1'b1;
    end

    pwm_n = (state_n != IDLE) && (count_n < active_n);
  end

  always_ff @(posedge Clock_in or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      div_q     <= 1'b0;
      pwm_q     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      count_q   <= count_n;
      active_q  <= active_n;
      shadow_q  <= shadow_n;
      pending_q <= pending_n;
      div_q     <= bus.Clock_div;
      pwm_q     <= pwm_n;
      running_q <= (state_n != IDLE);
    end
  end

  assign bus.PWM_out      = pwm_q;
  assign bus.Duty_pending = pending_q;
  assign bus.Running      = running_q;

`ifdef PWM_PERIOD_PULSE_EN
  logic period_end_q;

  always_ff @(posedge Clock_in or posedge Reset) begin
    if (Reset) period_end_q <= 1'b0;
    else       period_end_q <= wrap;
  end

  assign bus.Period_end = period_end_q;
`endif

endmodule

// File: tb/tb_pwm_generador.sv
// Bench for pwm_generador with WIDTH=4, PERIOD=9: duty table plus drain, reload and reset sequences.
module tb_pwm_generador;
  localparam int W = 4;
  localparam int P = 9;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pwm_generador_if #(.WIDTH(W)) bus ();

  pwm_generador #(.WIDTH(W), .PERIOD(P)) dut (
    .Clock_in (clk),
    .Reset    (rst),
    .bus      (bus)
  );

  typedef struct {
    logic [W-1:0] duty;
    int           ticks;
    int           exp_high;
  } vec_t;

  vec_t vecs[5];
  logic exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   pe_cnt = 0;
  int   high;

  task automatic chk(input string name, input logic got, input logic exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0b, expected %0b", name, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
`ifdef PWM_PERIOD_PULSE_EN
    if (bus.Period_end === 1'b1) pe_cnt++;
`endif
  endtask

  // One divided-clock period: rising edge on the first cycle, low on the second.
  task automatic do_tick(input logic exp_pwm, input string name);
    logic e;
    bus.Clock_div = 1'b1;
    exp_q.push_back(exp_pwm);
    step();
    e = exp_q.pop_front();
    chk(name, bus.PWM_out, e);
    bus.Clock_div = 1'b0;
    step();
    chk({name, "_hold"}, bus.PWM_out, e);
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.Clock_div = 1'b0;
    bus.Enable    = 1'b0;
    bus.Duty      = '0;
    bus.Duty_load = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic load(input logic [W-1:0] d);
    bus.Duty      = d;
    bus.Duty_load = 1'b1;
    step();
    bus.Duty_load = 1'b0;
  endtask

  task automatic start(input logic [W-1:0] d);
    load(d);
    chk("load_pending", bus.Duty_pending, 1'b1);
    step();
    chk("apply_idle_pending", bus.Duty_pending, 1'b0);
    bus.Enable = 1'b1;
    step();
    chk("start_running", bus.Running, 1'b1);
    chk("start_pwm", bus.PWM_out, (d != 0));
  endtask

  initial begin
    rst           = 1'b1;
    bus.Clock_div = 1'b0;
    bus.Enable    = 1'b0;
    bus.Duty      = '0;
    bus.Duty_load = 1'b0;

    vecs[0] = '{4'd3,  20, 6};
    vecs[1] = '{4'd0,  20, 0};
    vecs[2] = '{4'd10, 20, 20};
    vecs[3] = '{4'd15, 20, 20};
    vecs[4] = '{4'd7,  20, 14};

    // Duty table: count after k ticks is k mod 10, output high while count < duty.
    foreach (vecs[i]) begin
      do_reset();
      chk("rst_pwm", bus.PWM_out, 1'b0);
      chk("rst_running", bus.Running, 1'b0);
      chk("rst_pending", bus.Duty_pending, 1'b0);
      start(vecs[i].duty);
      high = 0;
      for (int k = 1; k <= vecs[i].ticks; k++) begin
        do_tick(((k % 10) < int'(vecs[i].duty)), "vec_pwm");
        if (bus.PWM_out === 1'b1) high++;
      end
      chk_int("vec_high_ticks", high, vecs[i].exp_high);
    end

    // Idle with ticks, stuck divider, then asynchronous reset mid-run.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      do_tick(1'b0, "idle_pwm");
      chk("idle_running", bus.Running, 1'b0);
    end
    start(4'd3);
    for (int k = 1; k <= 3; k++) do_tick(((k % 10) < 3), "pre_stuck_pwm");
    bus.Clock_div = 1'b1;
    step();
    for (int c = 0; c < 5; c++) begin
      step();
      chk("stuck_hi_pwm", bus.PWM_out, 1'b0);
    end
    bus.Clock_div = 1'b0;
    step();
    for (int k = 5; k <= 11; k++) do_tick(((k % 10) < 3), "post_stuck_pwm");
    load(4'd6);
    chk("mid_load_pending", bus.Duty_pending, 1'b1);
    chk("pre_rst_pwm", bus.PWM_out, 1'b1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_pwm", bus.PWM_out, 1'b0);
    chk("async_rst_running", bus.Running, 1'b0);
    chk("async_rst_pending", bus.Duty_pending, 1'b0);
    step();
    rst = 1'b0;

    // Mid-period update: 3/10 period completes, then 7/10.
    do_reset();
    start(4'd3);
    for (int k = 1; k <= 5; k++) do_tick(((k % 10) < 3), "upd_pwm");
    load(4'd7);
    chk("upd_pending", bus.Duty_pending, 1'b1);
    for (int k = 6; k <= 9; k++) begin
      do_tick(1'b0, "upd_old_pwm");
      chk("upd_still_pending", bus.Duty_pending, 1'b1);
    end
    do_tick(1'b1, "upd_wrap_pwm");
    chk("upd_wrap_pending", bus.Duty_pending, 1'b0);
    for (int k = 11; k <= 17; k++) do_tick(((k % 10) < 7), "upd_new_pwm");

    // Drain to IDLE after the wrap.
    do_reset();
    start(4'd7);
    for (int k = 1; k <= 4; k++) do_tick(1'b1, "drain_run_pwm");
    bus.Enable = 1'b0;
    for (int k = 5; k <= 9; k++) begin
      do_tick((k < 7), "drain_pwm");
      chk("drain_running", bus.Running, 1'b1);
    end
    do_tick(1'b0, "drain_wrap_pwm");
    chk("drain_idle_running", bus.Running, 1'b0);
    for (int k = 0; k < 2; k++) do_tick(1'b0, "drain_after_pwm");

    // Re-enable during drain: period continues without a gap.
    do_reset();
    start(4'd7);
    for (int k = 1; k <= 4; k++) do_tick(1'b1, "reen_run_pwm");
    bus.Enable = 1'b0;
    for (int k = 5; k <= 6; k++) do_tick(1'b1, "reen_drain_pwm");
    bus.Enable = 1'b1;
    for (int k = 7; k <= 9; k++) do_tick(1'b0, "reen_pwm");
    do_tick(1'b1, "reen_wrap_pwm");
    chk("reen_running", bus.Running, 1'b1);
    do_tick(1'b1, "reen_next_pwm");

    // Duty_load coincident with the wrap tick.
    do_reset();
    start(4'd3);
    for (int k = 1; k <= 9; k++) do_tick(((k % 10) < 3), "coin_pre_pwm");
    bus.Duty      = 4'd5;
    bus.Duty_load = 1'b1;
    bus.Clock_div = 1'b1;
    exp_q.push_back(1'b1);
    step();
    bus.Duty_load = 1'b0;
    chk("coin_wrap_pwm", bus.PWM_out, exp_q.pop_front());
    chk("coin_pending", bus.Duty_pending, 1'b0);
    bus.Clock_div = 1'b0;
    step();
    for (int k = 11; k <= 16; k++) do_tick(((k % 10) < 5), "coin_new_pwm");

`ifdef PWM_PERIOD_PULSE_EN
    do_reset();
    start(4'd3);
    pe_cnt = 0;
    for (int k = 1; k <= 20; k++) do_tick(((k % 10) < 3), "pe_pwm");
    chk_int("period_end_pulses", pe_cnt, 2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pwm_generador.md
Name: pwm_generador

Overview:
- PWM generation stage directly downstream of the frequency divider.
- Samples the divider's divided-clock output as a data signal in the 100 MHz Clock_in domain and turns each rising edge into a one-cycle tick.
- Runs a period counter and compares it against a double-buffered duty value to drive PWM_out.
- Duty changes take effect only at period boundaries, so the output never glitches mid-period.

Parameters:
- WIDTH, 8, width of the counter, duty and shadow registers.
- PERIOD, 255, terminal count; period = PERIOD+1 ticks; legal range 1 .. 2^WIDTH-1.

Ports:
- Clock_in  input  1  system clock, 100 MHz; all logic on rising edge.
- Reset  input  1  asynchronous, active-high; clears all state.
- Clock_div  input  1  divided clock from the divider, registered in the Clock_in domain; used as data only, never as a clock.
- Enable  input  1  level; 1 = run, 0 = stop at the end of the current period.
- Duty  input  WIDTH  requested high-time in ticks.
- Duty_load  input  1  one-cycle strobe that captures Duty into the shadow register.
- PWM_out  output  1  registered PWM output.
- Duty_pending  output  1  shadow holds a value not yet applied.
- Running  output  1  state is RUN or DRAIN.

Behaviour:
- Reset values (async assert, then held until deassert):
  - count = 0, active = 0, shadow = 0, div_q = 0, state = IDLE.
  - PWM_out = 0, Duty_pending = 0, Running = 0.
- Tick detection:
  - div_q <= Clock_div every cycle.
  - tick = Clock_div & ~div_q: exactly one cycle per rising edge of the divided clock.
- Shadow register:
  - Duty_load = 1: shadow <= Duty, Duty_pending <= 1.
  - Values above PERIOD are stored unchanged; they yield 100 % duty.
- Apply point: a cycle where active <= shadow and Duty_pending <= 0. It occurs:
  - in IDLE, on any cycle with Duty_pending = 1;
  - in RUN or DRAIN, on a tick with count == PERIOD (wrap).
- Duty_load coincident with an apply point:
  - the incoming Duty is written to both shadow and active;
  - Duty_pending stays 0.
- Counter:
  - advances only on tick in RUN or DRAIN;
  - count == PERIOD -> 0 (wrap), otherwise count + 1;
  - no other wrap is possible.
- Compare:
  - computed on next-state values: PWM_out <= (state_next != IDLE) && (count_next < active_next);
  - PWM_out updates one Clock_in cycle after the tick cycle and otherwise holds.
  - Duty = 0 -> PWM_out constantly 0.
  - Duty >= PERIOD+1 -> PWM_out constantly 1 while running.
- FSM:
  - IDLE -> RUN: when Enable = 1; count = 0 and PWM_out = (0 < active) from the next cycle.
  - RUN -> DRAIN: when Enable = 0; counting continues.
  - DRAIN -> RUN: when Enable = 1 before the wrap, without interrupting the period.
  - DRAIN -> IDLE: on the wrap tick; count = 0, PWM_out = 0.
  - Tick and Enable change in the same cycle: the transition is taken first, then the tick is applied under the new state.
- Running = 1 in RUN or DRAIN, registered with the state.
- Reset mid-period: PWM_out drops to 0 asynchronously and the pending shadow is lost.
- Clock_div stuck at 0 or 1: no ticks; counter and output hold.

Optional Feature:
- Macro: PWM_PERIOD_PULSE_EN.
- Defined:
  - adds output Period_end (1 bit, reset 0);
  - Period_end is a one-Clock_in-cycle pulse registered alongside PWM_out on every wrap tick in RUN or DRAIN, including the final DRAIN wrap.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset and idle, WIDTH=4, PERIOD=9, Clock_div toggling: assert Reset mid-run -> PWM_out = Running = Duty_pending = 0 within the same cycle; no activity while Enable = 0.
- Basic duty: Duty = 3 loaded in IDLE, then Enable = 1 -> Duty_pending clears after 1 cycle; PWM_out is high for 3 ticks and low for 7, repeating every 10 ticks.
- Mid-period update: while running at Duty = 3, load Duty = 7 at count = 5 -> current period stays 3/10, Duty_pending = 1 until the wrap tick, next period is 7/10.
- Extremes: Duty = 0 -> PWM_out never rises; Duty = 10 and Duty = 15 -> PWM_out constantly 1 while running.
- Drain: drop Enable at count = 4 -> counting continues, PWM_out follows duty to count = 9, then IDLE with PWM_out = 0 and Running = 0; re-enable at count = 6 in a second run -> stays RUN with no gap.
- Coincidence and option: Duty_load (value 5) on the wrap-tick cycle -> the new period uses 5, Duty_pending = 0; with PWM_PERIOD_PULSE_EN, Period_end pulses exactly once per 10 ticks.
